// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage load/store unit: req/ack data bus, byte lanes, wait-state stall, timeout abort; optional MEM_ALIGN_CHECK_EN
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_in_M,
    input  logic [31:0] ALU_Out_in_M,
    input  logic [31:0] WriteData_in_M,
    input  logic [4:0]  WriteReg_in_M,
    output logic [31:0] Instr_out_M,
    output logic [4:0]  WriteReg_out_M,
    output logic [31:0] Data_out_dm,
    output logic        stall_M,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Last WAIT count before the access is abandoned as a bus error
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [31:0] rdata_q;
    logic        bus_err_q;

    logic [5:0]  opcode;
    logic [1:0]  lane;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        sign_ext;
    size_t       size;
    logic        misaligned;
    logic        issue;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    logic        req_c;
    logic        stall_c;
    logic        pass_c;
    logic [31:0] data_c;

    assign opcode = Instr_in_M[31:26];
    assign lane   = ALU_Out_in_M[1:0];
    assign is_mem = is_load | is_store;

    // Opcode decode into direction, access size and extension kind
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        size     = SZ_WORD;
        case (opcode)
            OP_LW:  begin is_load = 1'b1;  size = SZ_WORD; end
            OP_LB:  begin is_load = 1'b1;  size = SZ_BYTE; sign_ext = 1'b1; end
            OP_LBU: begin is_load = 1'b1;  size = SZ_BYTE; end
            OP_LH:  begin is_load = 1'b1;  size = SZ_HALF; sign_ext = 1'b1; end
            OP_LHU: begin is_load = 1'b1;  size = SZ_HALF; end
            OP_SW:  begin is_store = 1'b1; size = SZ_WORD; end
            OP_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
            OP_SH:  begin is_store = 1'b1; size = SZ_HALF; end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned words/halves are refused instead of being silently realigned
    assign misaligned = is_mem &&
                        (((size == SZ_WORD) && (lane != 2'b00)) ||
                         ((size == SZ_HALF) && lane[0]));
`else
    // Without the check, words ignore the low bits and halves use lane[1] only
    assign misaligned = 1'b0;
`endif

    assign issue = is_mem & ~misaligned;

    // Bus address is always word aligned; lanes pick the bytes
    assign mem_addr = {ALU_Out_in_M[31:2], 2'b00};

    // Byte enables and lane-replicated store data
    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = WriteData_in_M;
        case (size)
            SZ_BYTE: begin
                mem_be    = 4'b0001 << lane;
                mem_wdata = {4{WriteData_in_M[7:0]}};
            end
            SZ_HALF: begin
                mem_be    = lane[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{WriteData_in_M[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection and sign/zero extension of returned read data
    always_comb begin
        case (lane)
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size)
            SZ_BYTE: load_ext = {{24{sign_ext & load_byte[7]}}, load_byte};
            SZ_HALF: load_ext = {{16{sign_ext & load_half[15]}}, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // State register, wait counter, captured load data and error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt       <= '0;
                    bus_err_q <= misaligned;
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        rdata_q <= is_load ? load_ext : 32'h0;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q   <= 32'h0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Next-state: stall on a missed ack, leave WAIT on ack or timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue && !mem_ack) state_nxt = S_WAIT;
            S_WAIT:  if (mem_ack || (cnt == CNT_LAST)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-state bus request, stall and load data selection
    always_comb begin
        req_c   = 1'b0;
        stall_c = 1'b0;
        pass_c  = 1'b1;
        data_c  = 32'h0;
        case (state)
            S_IDLE: begin
                req_c  = issue;
                pass_c = ~misaligned;
                if (issue && !mem_ack) begin
                    stall_c = 1'b1;
                end else if (issue && is_load) begin
                    data_c = load_ext;
                end
            end
            S_WAIT: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
            end
            S_DONE: begin
                data_c = rdata_q;
            end
            default: ;
        endcase
    end

    // Reset masks the bus and pipeline controls immediately; stalls send bubbles to M/W
    always_comb begin
        mem_req        = req_c & ~reset;
        mem_we         = req_c & is_store & ~reset;
        stall_M        = stall_c & ~reset;
        bus_err        = bus_err_q & ~reset;
        Data_out_dm    = (stall_M || !pass_c) ? 32'h0 : data_c;
        Instr_out_M    = (stall_M || !pass_c) ? 32'h0 : Instr_in_M;
        WriteReg_out_M = (stall_M || !pass_c) ? 5'd0 : WriteReg_in_M;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized and directed checks of mem_access_stage against a behavioural model
module tb_mem_access_stage;

    localparam int T = 4;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_in_M;
    logic [31:0] ALU_Out_in_M;
    logic [31:0] WriteData_in_M;
    logic [4:0]  WriteReg_in_M;
    logic [31:0] Instr_out_M;
    logic [4:0]  WriteReg_out_M;
    logic [31:0] Data_out_dm;
    logic        stall_M;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int tests = 0;
    int fails = 0;

    logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                             6'h28, 6'h29, 6'h2B, 6'h00, 6'h08};

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .reset          (reset),
        .Instr_in_M     (Instr_in_M),
        .ALU_Out_in_M   (ALU_Out_in_M),
        .WriteData_in_M (WriteData_in_M),
        .WriteReg_in_M  (WriteReg_in_M),
        .Instr_out_M    (Instr_out_M),
        .WriteReg_out_M (WriteReg_out_M),
        .Data_out_dm    (Data_out_dm),
        .stall_M        (stall_M),
        .bus_err        (bus_err),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one instruction just after a rising edge; the bench acts as memory,
    // raising ack from cycle 'lat' of the access onward and holding it.
    task automatic run_access(input logic [31:0] instr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [4:0] wr,
                              input int lat, input logic [31:0] rdata,
                              output logic [31:0] dout, output int stalls);
        int          op, size, a, exp_stall;
        bit          is_ld, is_st, is_mem, sgn, misal, tmo, done;
        logic [31:0] exp_be, exp_wd, exp_ld, v;
        op     = int'(instr[31:26]);
        a      = int'(addr[1:0]);
        is_ld  = op inside {'h20, 'h21, 'h23, 'h24, 'h25};
        is_st  = op inside {'h28, 'h29, 'h2B};
        is_mem = is_ld || is_st;
        size   = (op == 'h23 || op == 'h2B) ? 4 : (op == 'h21 || op == 'h25 || op == 'h29) ? 2 : 1;
        sgn    = (op == 'h20 || op == 'h21);
        misal  = ALIGN_EN && is_mem && ((size == 4 && a != 0) || (size == 2 && (a % 2) == 1));
        if (size == 4) begin
            exp_be = 32'hF;
            exp_wd = wd;
            exp_ld = rdata;
        end else if (size == 2) begin
            exp_be = (a >= 2) ? 32'hC : 32'h3;
            exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
            v = (rdata >> (16 * (a / 2))) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
            exp_ld = v;
        end else begin
            exp_be = 32'd1 << a;
            exp_wd = (wd & 32'hFF) * 32'h0101_0101;
            v = (rdata >> (8 * a)) & 32'hFF;
            if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
            exp_ld = v;
        end
        tmo = 1'b0;
        exp_stall = 0;
        if (is_mem && !misal && lat > 0) begin
            tmo = (lat > T);
            exp_stall = (tmo ? T : lat) + 1;
        end

        Instr_in_M     = instr;
        ALU_Out_in_M   = addr;
        WriteData_in_M = wd;
        WriteReg_in_M  = wr;
        mem_rdata      = rdata;
        mem_ack        = (lat == 0);
        stalls = 0;
        dout   = '0;
        done   = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("req_issue", 32'(mem_req), 32'(is_mem && !misal));
                if (is_mem && !misal) begin
                    check("mem_we", 32'(mem_we), 32'(is_st));
                    check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                    check("mem_be", 32'(mem_be), exp_be);
                    if (is_st) check("mem_wdata", mem_wdata, exp_wd);
                end
            end
            if (stall_M) begin
                stalls++;
                check("bubble_instr", Instr_out_M, 32'h0);
                check("bubble_wreg", 32'(WriteReg_out_M), 32'h0);
                check("stall_bus_err", 32'(bus_err), 32'h0);
                if (c == 63) check("stall_bound", 32'(stalls), 32'(exp_stall));
                @(posedge clk);
                #1;
                mem_ack = (c + 1 >= lat);
            end else begin
                done = 1'b1;
                check("pass_instr", Instr_out_M, misal ? 32'h0 : instr);
                check("pass_wreg", 32'(WriteReg_out_M), misal ? 32'h0 : 32'(wr));
                check("load_data", Data_out_dm, (is_ld && !tmo && !misal) ? exp_ld : 32'h0);
                check("done_bus_err", 32'(bus_err), 32'(tmo));
                check("done_req", 32'(mem_req), 32'(exp_stall == 0 && is_mem && !misal));
                dout = Data_out_dm;
            end
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        if (misal) begin
            Instr_in_M = 32'h0;
            @(negedge clk);
            check("misalign_bus_err", 32'(bus_err), 32'h1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] dout;
        int          stalls;

        reset          = 1'b1;
        Instr_in_M     = 32'h0;
        ALU_Out_in_M   = 32'h0;
        WriteData_in_M = 32'h0;
        WriteReg_in_M  = 5'd0;
        mem_rdata      = 32'h0;
        mem_ack        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_stall", 32'(stall_M), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_data", Data_out_dm, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // lw, zero wait
        run_access({6'h23, 26'h0A5_1234}, 32'h10, 32'h0, 5'd8, 0, 32'hDEAD_BEEF, dout, stalls);
        check("lw_data", dout, 32'hDEAD_BEEF);
        check("lw_stalls", 32'(stalls), 32'd0);

        // lb / lbu at byte 3, ack in the fourth cycle
        run_access({6'h20, 26'h0}, 32'h13, 32'h0, 5'd9, 3, 32'h8011_2233, dout, stalls);
        check("lb_data", dout, 32'hFFFF_FF80);
        check("lb_stalls", 32'(stalls), 32'd4);
        run_access({6'h24, 26'h0}, 32'h13, 32'h0, 5'd9, 3, 32'h8011_2233, dout, stalls);
        check("lbu_data", dout, 32'h0000_0080);

        // sh to upper half
        run_access({6'h29, 26'h0}, 32'h06, 32'h0000_ABCD, 5'd0, 1, 32'h0, dout, stalls);
        check("sh_data", dout, 32'h0);

        // lw with no ack: timeout abort, then a normal lw
        run_access({6'h23, 26'h0}, 32'h20, 32'h0, 5'd3, 1000, 32'h1234_5678, dout, stalls);
        check("tmo_stalls", 32'(stalls), 32'd5);
        check("tmo_data", dout, 32'h0);
        run_access({6'h23, 26'h0}, 32'h24, 32'h0, 5'd3, 0, 32'hCAFE_F00D, dout, stalls);
        check("post_tmo_data", dout, 32'hCAFE_F00D);

        // misaligned lw
        run_access({6'h23, 26'h0}, 32'h02, 32'h0, 5'd4, 0, 32'h0BAD_CAFE, dout, stalls);

        // reset during WAIT cycle 2
        Instr_in_M   = {6'h23, 26'h0};
        ALU_Out_in_M = 32'h40;
        mem_ack      = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("wait_stall", 32'(stall_M), 32'h1);
        check("wait_req", 32'(mem_req), 32'h1);
        reset      = 1'b1;
        Instr_in_M = {6'h00, 26'h0A2_0021};
        #1;
        check("mid_rst_req", 32'(mem_req), 32'h0);
        check("mid_rst_stall", 32'(stall_M), 32'h0);
        check("mid_rst_we", 32'(mem_we), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_access({6'h00, 26'h0A2_0021}, 32'h0, 32'h0, 5'd2, 0, 32'h0, dout, stalls);
        check("addu_stalls", 32'(stalls), 32'd0);
        run_access({6'h23, 26'h0}, 32'h40, 32'h0, 5'd5, 0, 32'h7777_0001, dout, stalls);
        check("post_rst_lw", dout, 32'h7777_0001);

        // randomized mix of ops, addresses and latencies
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ins;
            int          lat;
            ins = {ops[$urandom_range(0, 9)], 26'($urandom)};
            lat = ($urandom_range(0, 7) == 7) ? 50 : int'($urandom_range(0, 5));
            run_access(ins, $urandom, $urandom, 5'($urandom), lat, $urandom, dout, stalls);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
